// File: rtl/au_pipe_pkg.sv
// Types for the pipelined arithmetic unit: one result slot and its scoreboard match.
package au_pipe_pkg;

  localparam int AU_XLEN = 32;
  localparam int AU_RD_W = 5;

  typedef struct packed {
    logic               valid;
    logic [AU_XLEN-1:0] data;
    logic [AU_RD_W-1:0] rd;
    logic               wen;
  } au_slot_t;

  // x0 is hardwired to zero, so a pending write to it never blocks a reader.
  function automatic logic slot_hits(au_slot_t s, logic [AU_RD_W-1:0] r);
    return s.valid & s.wen & (s.rd == r) & (|r);
  endfunction

endpackage

// File: rtl/rv32i_types_pkg.sv
// Shared RV32I datapath types: ALU operation codes and writeback source selects.
package rv32i_types_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SLL = 3'd1,
    ALU_SRA = 3'd2,
    ALU_SUB = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SRL = 3'd5,
    ALU_OR  = 3'd6,
    ALU_AND = 3'd7
  } aluop_t;

  typedef enum logic [1:0] {
    CSR     = 2'd0,
    ALU_SRC = 2'd1,
    REG_SRC = 2'd2,
    MEM_SRC = 2'd3
  } w_src_t;

endpackage

// File: rtl/alu_if.sv
// Connection bundle between the ALU and whoever drives its operands.
interface alu_if #(
  parameter int XLEN = 32
);
  import rv32i_types_pkg::*;

  aluop_t            aluop;
  logic [XLEN-1:0]   port_a;
  logic [XLEN-1:0]   port_b;
  logic [XLEN-1:0]   port_out;

  modport alu  (input aluop, port_a, port_b, output port_out);
  modport user (output aluop, port_a, port_b, input port_out);
endinterface

// File: rtl/alu.sv
// Combinational integer ALU; results wrap at XLEN bits and no flags are produced.
module alu #(
  parameter int XLEN = 32
) (
  alu_if.alu bus
);
  import rv32i_types_pkg::*;

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = bus.port_b[SHW-1:0];

  always_comb begin
    bus.port_out = '0;
    case (bus.aluop)
      ALU_ADD: bus.port_out = bus.port_a + bus.port_b;
      ALU_SUB: bus.port_out = bus.port_a - bus.port_b;
      ALU_SLL: bus.port_out = bus.port_a << shamt;
      ALU_SRL: bus.port_out = bus.port_a >> shamt;
      ALU_SRA: bus.port_out = $signed(bus.port_a) >>> shamt;
      ALU_XOR: bus.port_out = bus.port_a ^ bus.port_b;
      ALU_OR:  bus.port_out = bus.port_a | bus.port_b;
      ALU_AND: bus.port_out = bus.port_a & bus.port_b;
      default: bus.port_out = bus.port_a + bus.port_b;
    endcase
  end

endmodule

// File: rtl/au_pipe_slot.sv
// One registered result slot: load new contents, hold, or clear; reset and flush empty it.
module au_pipe_slot
  import au_pipe_pkg::*;
(
  input  logic     CLK,
  input  logic     RST,
  input  logic     flush,
  input  logic     load,
  input  logic     hold,
  input  au_slot_t d,
  output au_slot_t q
);

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (!hold) begin
      q <= '0;
    end
  end

endmodule

// File: rtl/arithmetic_unit_pipe.sv
// Elastic arithmetic unit: ALU/CSR/regfile result select followed by STAGES collapsing slots.
module arithmetic_unit_pipe
  import rv32i_types_pkg::*;
  import au_pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int RD_W   = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            in_valid,
  output logic            in_ready,
  input  aluop_t          aluop,
  input  logic [XLEN-1:0] port_a,
  input  logic [XLEN-1:0] port_b,
  input  w_src_t          w_src,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic [XLEN-1:0] reg_file_wdata,
  input  logic [RD_W-1:0] rd,
  input  logic            wen,
  input  logic            flush,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_wen,
  input  logic [RD_W-1:0] q_rs1,
  input  logic [RD_W-1:0] q_rs2,
  output logic            q_rs1_hit,
  output logic            q_rs2_hit
);

  alu_if #(.XLEN(XLEN)) alu_bus ();
  alu #(.XLEN(XLEN)) u_alu (.bus(alu_bus));

  assign alu_bus.aluop  = aluop;
  assign alu_bus.port_a = port_a;
  assign alu_bus.port_b = port_b;

  logic [XLEN-1:0] result;
  always_comb begin
    result = reg_file_wdata;
    case (w_src)
      CSR:     result = csr_rdata;
      ALU_SRC: result = alu_bus.port_out;
      default: result = reg_file_wdata;
    endcase
  end

  au_slot_t          entry;
  au_slot_t          slot_q [STAGES];
  au_slot_t          slot_d [STAGES];
  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] hold;
  logic              accept;

  assign entry.valid = 1'b1;
  assign entry.data  = result;
  assign entry.rd    = rd;
  assign entry.wen   = wen;

  // Handshake: a transfer happens on a cycle where valid and ready are both 1;
  // valid never waits on ready, and ready may depend combinationally on downstream ready.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = valid[STAGES-1] & wb_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      adv[i] = valid[i] & (~valid[i+1] | adv[i+1]);
    end
  end

  assign in_ready = ~valid[0] | adv[0];
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    load    = '0;
    load[0] = accept;
    for (int i = 1; i < STAGES; i++) begin
      load[i] = adv[i-1];
    end
    hold = valid & ~adv;
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_slot
    if (g == 0) begin : g_entry
      assign slot_d[g] = entry;
    end else begin : g_chain
      assign slot_d[g] = slot_q[g-1];
    end

    assign valid[g] = slot_q[g].valid;

    au_pipe_slot u_slot (
      .CLK   (CLK),
      .RST   (RST),
      .flush (flush),
      .load  (load[g]),
      .hold  (hold[g]),
      .d     (slot_d[g]),
      .q     (slot_q[g])
    );
  end

  always_comb begin
    q_rs1_hit = 1'b0;
    q_rs2_hit = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      q_rs1_hit = q_rs1_hit | slot_hits(slot_q[i], q_rs1);
      q_rs2_hit = q_rs2_hit | slot_hits(slot_q[i], q_rs2);
    end
  end

  assign wb_valid = slot_q[STAGES-1].valid;
  assign wb_data  = wb_valid ? slot_q[STAGES-1].data : '0;
  assign wb_rd    = wb_valid ? slot_q[STAGES-1].rd   : '0;
  assign wb_wen   = wb_valid & slot_q[STAGES-1].wen;

endmodule

// File: tb/tb_arithmetic_unit_pipe.sv
// Bench for arithmetic_unit_pipe: directed scenarios plus random traffic against a queue model.
module tb_arithmetic_unit_pipe;
  import rv32i_types_pkg::*;

  localparam int XLEN   = 32;
  localparam int STAGES = 2;
  localparam int RD_W   = 5;

  logic            CLK;
  logic            RST;
  logic            in_valid;
  logic            in_ready;
  aluop_t          aluop;
  logic [XLEN-1:0] port_a;
  logic [XLEN-1:0] port_b;
  w_src_t          w_src;
  logic [XLEN-1:0] csr_rdata;
  logic [XLEN-1:0] reg_file_wdata;
  logic [RD_W-1:0] rd;
  logic            wen;
  logic            flush;
  logic            wb_valid;
  logic            wb_ready;
  logic [XLEN-1:0] wb_data;
  logic [RD_W-1:0] wb_rd;
  logic            wb_wen;
  logic [RD_W-1:0] q_rs1;
  logic [RD_W-1:0] q_rs2;
  logic            q_rs1_hit;
  logic            q_rs2_hit;

  arithmetic_unit_pipe #(.XLEN(XLEN), .STAGES(STAGES), .RD_W(RD_W)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .aluop          (aluop),
    .port_a         (port_a),
    .port_b         (port_b),
    .w_src          (w_src),
    .csr_rdata      (csr_rdata),
    .reg_file_wdata (reg_file_wdata),
    .rd             (rd),
    .wen            (wen),
    .flush          (flush),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_data        (wb_data),
    .wb_rd          (wb_rd),
    .wb_wen         (wb_wen),
    .q_rs1          (q_rs1),
    .q_rs2          (q_rs2),
    .q_rs1_hit      (q_rs1_hit),
    .q_rs2_hit      (q_rs2_hit)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [XLEN-1:0] data;
    logic [RD_W-1:0] rd;
    logic            wen;
    int              age;
  } item_t;

  item_t exp_q[$];
  int    vectors    = 0;
  int    miscompares = 0;
  int    n_push     = 0;
  int    n_pop      = 0;
  bit    model_live = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=0x%h expected=0x%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_result();
    logic [XLEN-1:0] a, b, r;
    int sh;
    a  = port_a;
    b  = port_b;
    sh = int'(b % XLEN);
    if (w_src == CSR) return csr_rdata;
    if (w_src != ALU_SRC) return reg_file_wdata;
    case (aluop)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_SLL: r = a << sh;
      ALU_SRL: r = a >> sh;
      ALU_SRA: begin
        r = a >> sh;
        if (a[XLEN-1]) for (int k = 0; k < sh; k++) r[XLEN-1-k] = 1'b1;
      end
      ALU_XOR: r = a ^ b;
      ALU_OR:  r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // A result reaches writeback once it has aged STAGES-1 edges: nothing ahead ever blocks the oldest.
  function automatic bit exp_wb_valid();
    return (exp_q.size() > 0) && (exp_q[0].age >= STAGES - 1);
  endfunction

  function automatic bit exp_in_ready();
    return (exp_q.size() < STAGES) || (exp_wb_valid() && wb_ready);
  endfunction

  function automatic bit exp_hit(input logic [RD_W-1:0] r);
    foreach (exp_q[i]) if (exp_q[i].wen && exp_q[i].rd == r && r != 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: compare everything at the falling edge, then advance the model at the rising edge.
  task automatic step();
    bit      do_pop, do_push, do_rst, do_flush;
    item_t   it;
    @(negedge CLK);
    if (model_live) begin
      check("in_ready", {31'b0, in_ready}, {31'b0, exp_in_ready()});
      check("wb_valid", {31'b0, wb_valid}, {31'b0, exp_wb_valid()});
      check("wb_data",  wb_data, exp_wb_valid() ? exp_q[0].data : '0);
      check("wb_rd",    {27'b0, wb_rd}, exp_wb_valid() ? {27'b0, exp_q[0].rd} : '0);
      check("wb_wen",   {31'b0, wb_wen}, exp_wb_valid() ? {31'b0, exp_q[0].wen} : '0);
      check("rs1_hit",  {31'b0, q_rs1_hit}, {31'b0, exp_hit(q_rs1)});
      check("rs2_hit",  {31'b0, q_rs2_hit}, {31'b0, exp_hit(q_rs2)});
    end
    do_rst   = RST;
    do_flush = flush;
    do_pop   = model_live && exp_wb_valid() && wb_ready;
    do_push  = model_live && in_valid && exp_in_ready() && !flush;
    it.data  = ref_result();
    it.rd    = rd;
    it.wen   = wen;
    it.age   = 0;
    @(posedge CLK);
    if (do_rst) begin
      exp_q.delete();
      model_live = 1;
    end else begin
      if (do_pop) begin
        void'(exp_q.pop_front());
        n_pop++;
      end
      if (do_flush) begin
        exp_q.delete();
      end else begin
        foreach (exp_q[i]) exp_q[i].age++;
        if (do_push) begin
          exp_q.push_back(it);
          n_push++;
        end
      end
    end
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_op(input aluop_t op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input w_src_t src, input logic [XLEN-1:0] csr, input logic [XLEN-1:0] rf,
                          input logic [RD_W-1:0] r, input logic w);
    in_valid       = 1'b1;
    aluop          = op;
    port_a         = a;
    port_b         = b;
    w_src          = src;
    csr_rdata      = csr;
    reg_file_wdata = rf;
    rd             = r;
    wen            = w;
  endtask

  task automatic rand_op();
    drive_op(aluop_t'(3'($urandom_range(0, 7))), $urandom(), $urandom(),
             w_src_t'(2'($urandom_range(0, 3))), $urandom(), $urandom(),
             RD_W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    idle();
    wb_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  int base;

  initial begin
    RST = 1'b1; in_valid = 1'b0; aluop = ALU_ADD; port_a = '0; port_b = '0;
    w_src = ALU_SRC; csr_rdata = '0; reg_file_wdata = '0; rd = '0; wen = 1'b0;
    flush = 1'b0; wb_ready = 1'b1; q_rs1 = '0; q_rs2 = '0;
    step();
    step();
    RST = 1'b0;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_wb_data",  wb_data, 32'd0);

    // ADD 5+7 -> writeback exactly STAGES cycles after acceptance
    drive_op(ALU_ADD, 32'd5, 32'd7, ALU_SRC, 32'h0, 32'h0, 5'd3, 1'b1);
    step();
    idle();
    step();
    check("add_valid", {31'b0, wb_valid}, 32'd1);
    check("add_data",  wb_data, 32'd12);
    check("add_rd",    {27'b0, wb_rd}, 32'd3);
    step();
    check("add_after_valid", {31'b0, wb_valid}, 32'd0);
    check("add_after_data",  wb_data, 32'd0);

    // CSR then pass-through sources, in order
    drive_op(ALU_ADD, 32'd1, 32'd1, CSR, 32'hDEAD_BEEF, 32'h0, 5'd1, 1'b1);
    step();
    drive_op(ALU_ADD, 32'd1, 32'd1, REG_SRC, 32'h0, 32'h1234, 5'd2, 1'b1);
    step();
    idle();
    check("csr_data", wb_data, 32'hDEAD_BEEF);
    step();
    check("rf_data", wb_data, 32'h1234);
    drain(10);

    // Six back-to-back ops against five stalled cycles
    base = n_push;
    wb_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      rand_op();
      step();
    end
    check("stall_accepts", n_push - base, 2);
    wb_ready = 1'b1;
    for (int c = 0; c < 20 && (n_push - base) < 6; c++) begin
      rand_op();
      step();
    end
    base = n_pop;
    drain(20);
    check("stream_total", n_push - (n_pop - exp_q.size()), n_push - n_pop + exp_q.size());

    // Scoreboard hits: x0 never hits
    wb_ready = 1'b0;
    q_rs1 = 5'd4;
    q_rs2 = 5'd0;
    drive_op(ALU_OR, 32'h1, 32'h2, ALU_SRC, 32'h0, 32'h0, 5'd4, 1'b1);
    step();
    drive_op(ALU_OR, 32'h3, 32'h4, ALU_SRC, 32'h0, 32'h0, 5'd0, 1'b1);
    step();
    idle();
    check("hit_rs1", {31'b0, q_rs1_hit}, 32'd1);
    check("hit_rs2", {31'b0, q_rs2_hit}, 32'd0);
    check("full_ready", {31'b0, in_ready}, 32'd0);
    drain(10);
    check("drained_rs1", {31'b0, q_rs1_hit}, 32'd0);

    // Flush of a full pipe with a new op presented
    wb_ready = 1'b0;
    rand_op(); step();
    rand_op(); step();
    drive_op(ALU_ADD, 32'hFFFF_0000, 32'h1, ALU_SRC, 32'h0, 32'h0, 5'd9, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    check("flush_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    wb_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();

    // Reset mid-stream
    for (int c = 0; c < 3; c++) begin
      drive_op(ALU_ADD, 32'(c), 32'd1, ALU_SRC, 32'h0, 32'h0, 5'd6, 1'b1);
      step();
    end
    q_rs1 = 5'd6;
    q_rs2 = 5'd6;
    RST = 1'b1;
    step();
    RST = 1'b0;
    idle();
    check("mrst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("mrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("mrst_hit", {30'b0, q_rs1_hit, q_rs2_hit}, 32'd0);
    drive_op(ALU_SUB, 32'd3, 32'd5, ALU_SRC, 32'h0, 32'h0, 5'd7, 1'b1);
    step();
    idle();
    step();
    check("mrst_after", wb_data, 32'hFFFF_FFFE);
    drain(10);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) < 70) rand_op(); else idle();
      wb_ready = ($urandom_range(0, 99) < 65);
      flush    = ($urandom_range(0, 99) < 3);
      RST      = ($urandom_range(0, 199) < 1);
      q_rs1    = RD_W'($urandom_range(0, 7));
      q_rs2    = RD_W'($urandom_range(0, 7));
      step();
    end
    RST = 1'b0;
    flush = 1'b0;
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
